// File: rtl/demux_rr_scheduler.sv
// -----------------------------------------------------------------------------
// demux_rr_scheduler
// Sequencing controller for a 1:8 demultiplexer. Accepts words over a
// valid/ready handshake, holds one word in an output register and steers it
// to a destination channel chosen round-robin over an enable mask, with
// BURST consecutive words per channel before rotating.
//
// Ports:
//   clk_i         clock, all logic on rising edge
//   rst_i         synchronous active-high reset
//   chan_en_i     channel enable mask (affects new accepts only)
//   in_valid_i    upstream word valid
//   in_data_i     upstream word
//   in_ready_o    block accepts in_data_i this cycle (combinational)
//   dst_ready_i   per-channel destination ready
//   sel_o         demux select = channel of held word (registered)
//   out_valid_o   one-hot valid for the held word, 0 when idle (registered)
//   out_data_o    held word (registered)
//   word_count_o  words delivered since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
module demux_rr_scheduler #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BURST  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        chan_en_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    input  logic [7:0]        dst_ready_i,
    output logic [2:0]        sel_o,
    output logic [7:0]        out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [15:0]       word_count_o
);

    localparam int unsigned N_CH   = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BCNT_W = 5;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, cur_q, ptr_q;
    logic [SEL_W-1:0]    sel_d, search_c;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d, bcnt_base_c, bcnt_inc_c;
    logic [N_CH-1:0]     out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [CNT_W-1:0]    word_count_q;
    logic                deliver_c, accept_c, cont_c, found_c;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = HOLD;
            HOLD:    if (deliver_c && !accept_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs; a delivery frees the register in the same cycle
    always_comb begin
        deliver_c  = (state_q == HOLD) && dst_ready_i[sel_q];
        in_ready_o = (chan_en_i != '0) && ((state_q == IDLE) || deliver_c);
        accept_c   = in_valid_i && in_ready_o;
    end

    // First enabled channel at or after ptr_q, wrapping
    always_comb begin
        search_c = ptr_q;
        found_c  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found_c && chan_en_i[ptr_q + SEL_W'(i)]) begin
                search_c = ptr_q + SEL_W'(i);
                found_c  = 1'b1;
            end
        end
    end

    // Burst continues only if it is mid-way and its channel is still enabled;
    // otherwise counting restarts at the newly chosen channel.
    always_comb begin
        cont_c      = (bcnt_q != '0) && chan_en_i[cur_q];
        sel_d       = cont_c ? cur_q : search_c;
        bcnt_base_c = cont_c ? bcnt_q : '0;
        bcnt_inc_c  = bcnt_base_c + BCNT_W'(1);
        bcnt_d      = (bcnt_inc_c == BCNT_W'(BURST)) ? '0 : bcnt_inc_c;
    end

    // Output register, scheduling pointers and delivery counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q        <= '0;
            cur_q        <= '0;
            ptr_q        <= '0;
            bcnt_q       <= '0;
            out_valid_q  <= '0;
            out_data_q   <= '0;
            word_count_q <= '0;
        end else begin
            if (accept_c) begin
                sel_q       <= sel_d;
                cur_q       <= sel_d;
                ptr_q       <= sel_d + SEL_W'(1);
                bcnt_q      <= bcnt_d;
                out_data_q  <= in_data_i;
                out_valid_q <= N_CH'(1) << sel_d;
            end else if (deliver_c) begin
                out_valid_q <= '0;
            end
            if (deliver_c) begin
                word_count_q <= word_count_q + CNT_W'(1);
            end
        end
    end

    assign sel_o        = sel_q;
    assign out_valid_o  = out_valid_q;
    assign out_data_o   = out_data_q;
    assign word_count_o = word_count_q;

endmodule

// File: doc/demux_rr_scheduler.md
Name: demux_rr_scheduler

Overview:
- Sequencing controller for the 1:8 demultiplexer datapath.
- Accepts a stream of data words over a valid/ready handshake and steers each word to one of 8 destination channels.
- Channel order is round-robin over a software enable mask, with a configurable burst length per channel.
- Holds one word in an output register and drives the demux select plus a one-hot per-channel valid.

Parameters:
- DATA_W, 8, width of each data word.
- BURST, 1, consecutive words sent to one channel before rotating (legal range 1..16).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- chan_en  input  8  channel enable mask; bit k = channel k may receive new words.
- in_valid  input  1  upstream word valid.
- in_data  input  DATA_W  upstream word.
- in_ready  output  1  block accepts in_data this cycle (combinational).
- dst_ready  input  8  per-channel destination ready.
- sel  output  3  demux select = channel of the held word (registered).
- out_valid  output  8  one-hot valid; bit sel set while a word is held, else 0.
- out_data  output  DATA_W  held word (registered).
- word_count  output  16  words delivered since reset; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst high at clk edge):
  - state=IDLE; sel=0; out_valid=0; out_data=0; word_count=0.
  - Internal ptr=0, cur=0, bcnt=0.
  - Any held word is discarded.
- States:
  - IDLE: nothing held.
  - HOLD: a word is held for channel sel.
- Delivery:
  - deliver = (state==HOLD) && dst_ready[sel].
  - Each delivery increments word_count by 1.
- Accept:
  - accept = in_valid && in_ready.
  - in_ready = (chan_en != 0) && (state==IDLE || deliver).
  - Full-throughput pipeline: a word may be delivered and a new word accepted in the same cycle; no bubble.
- Target selection on accept, using chan_en sampled that cycle:
  - if bcnt != 0 and chan_en[cur]=1: target = cur (burst continues).
  - otherwise: target = first k with chan_en[k]=1, searching ptr, ptr+1, ..., wrapping mod 8.
- Register update on accept:
  - sel = target; cur = target; out_data = in_data; state = HOLD.
  - ptr = (target+1) mod 8.
  - if bcnt+1 == BURST (or the burst was broken): bcnt = (BURST==1 ? 0 : new count) per the rule — bcnt = 0 when burst completes, else bcnt+1. A broken burst restarts counting at the new target, so bcnt = (BURST==1 ? 0 : 1).
- State transitions:
  - HOLD -> IDLE on deliver without accept.
  - HOLD -> HOLD on deliver with accept (new target), or when not delivered.
  - IDLE -> HOLD on accept.
- Held-word stability: while HOLD and not deliver, sel, out_data and out_valid are stable, regardless of in_valid or chan_en changes.
- Mask cleared mid-hold: a held word stays with its channel even if chan_en[sel] drops; the mask affects only new accepts.
- chan_en == 0: in_ready=0; a held word still delivers normally.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N; earliest delivery is the cycle following acceptance.
- No combinational path from in_data to outputs. in_ready depends combinationally on dst_ready, state and chan_en only.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0x00, sel=0, word_count=0, in_ready=1 (chan_en=0xFF).
- Round-robin full rate: BURST=1, chan_en=0xFF, dst_ready=0xFF, 16 back-to-back words 0x10..0x1F -> out_valid=0x01,0x02,...,0x80,0x01,... one per cycle; sel 0..7,0..7; word_count=16; in_ready held 1.
- Masked skipping: chan_en=0x24, 4 words -> delivered to channels 2,5,2,5; out_valid=0x04,0x20,0x04,0x20.
- Backpressure: hold word 0xA5 on channel 3 with dst_ready[3]=0 for 5 cycles -> in_ready=0, out_data=0xA5, out_valid=0x08 stable; raise dst_ready[3] -> delivered, word_count +1.
- Burst mode: BURST=2, chan_en=0xFF, 6 words -> channels 0,0,1,1,2,2. Then clear chan_en[3] while the burst is on channel 3 after its first word -> next word goes to channel 4.
- Reset mid-operation and all-masked: assert rst while HOLD -> next cycle out_valid=0, held word lost. Set chan_en=0 -> in_ready=0, no accepts. word_count wrap: preload 0xFFFF deliveries (or force) -> next delivery gives 0.
